// File: rtl/axi2apb_pkg.sv
// axi2apb type package: AXI4-Lite / APB request and response structs,
// bridge FSM state type and AXI response codes.
package axi2apb;

   localparam int unsigned AddrWidth = 32;
   localparam int unsigned DataWidth = 32;
   localparam int unsigned StrbWidth = DataWidth / 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } state_e;

   typedef struct packed {
      logic [AddrWidth-1:0] aw_addr;
      logic [2:0]           aw_prot;
      logic                 aw_valid;
      logic [DataWidth-1:0] w_data;
      logic [StrbWidth-1:0] w_strb;
      logic                 w_valid;
      logic                 b_ready;
      logic [AddrWidth-1:0] ar_addr;
      logic [2:0]           ar_prot;
      logic                 ar_valid;
      logic                 r_ready;
   } axi_req_t;

   typedef struct packed {
      logic                 aw_ready;
      logic                 w_ready;
      logic [1:0]           b_resp;
      logic                 b_valid;
      logic                 ar_ready;
      logic [DataWidth-1:0] r_data;
      logic [1:0]           r_resp;
      logic                 r_valid;
   } axi_resp_t;

   typedef struct packed {
      logic [AddrWidth-1:0] paddr;
      logic [2:0]           pprot;
      logic                 penable;
      logic                 pwrite;
      logic [DataWidth-1:0] pwdata;
      logic [StrbWidth-1:0] pstrb;
   } apb_req_t;

   typedef struct packed {
      logic                 pready;
      logic [DataWidth-1:0] prdata;
      logic                 pslverr;
   } apb_resp_t;

endpackage

// File: rtl/axi2apb_bridge.sv
// AXI4-Lite to APB bridge for a single APB slave. One transfer in flight,
// round-robin between reads and writes on simultaneous requests.
// Optional ACCESS-phase timeout enabled by defining AXI2APB_TIMEOUT_EN.
module axi2apb_bridge
   import axi2apb::*;
#(
   parameter int unsigned TimeoutCycles = 16
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  axi_req_t  axi_req_i,
   output axi_resp_t axi_resp_o,
   output apb_req_t  apb_req_o,
   output logic      apb_psel_o,
   input  apb_resp_t apb_resp_i
);

   state_e               state_q, state_d;
   logic                 rr_last_write_q, rr_last_write_d;
   logic                 psel_q, psel_d;
   logic                 penable_q, penable_d;
   logic                 pwrite_q, pwrite_d;
   logic [AddrWidth-1:0] paddr_q, paddr_d;
   logic [2:0]           pprot_q, pprot_d;
   logic [DataWidth-1:0] pwdata_q, pwdata_d;
   logic [StrbWidth-1:0] pstrb_q, pstrb_d;
   logic                 b_valid_q, b_valid_d;
   logic                 r_valid_q, r_valid_d;
   logic                 slverr_q, slverr_d;
   logic [DataWidth-1:0] rdata_q, rdata_d;

   logic                 wr_req, rd_req;
   logic                 grant_wr, grant_rd;

`ifdef AXI2APB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
   logic [CntW-1:0]      cnt_q, cnt_d;
`else
   // TimeoutCycles has no effect without the timeout counter.
   logic                 unused_timeout_param;
   assign unused_timeout_param = (TimeoutCycles == 0);
`endif

   // A write needs both AW and W; a lone channel is not a request.
   assign wr_req = axi_req_i.aw_valid && axi_req_i.w_valid;
   assign rd_req = axi_req_i.ar_valid;

   // Next-state, arbitration and payload capture.
   always_comb begin
      state_d         = state_q;
      rr_last_write_d = rr_last_write_q;
      psel_d          = psel_q;
      penable_d       = penable_q;
      pwrite_d        = pwrite_q;
      paddr_d         = paddr_q;
      pprot_d         = pprot_q;
      pwdata_d        = pwdata_q;
      pstrb_d         = pstrb_q;
      b_valid_d       = b_valid_q;
      r_valid_d       = r_valid_q;
      slverr_d        = slverr_q;
      rdata_d         = rdata_q;
      grant_wr        = 1'b0;
      grant_rd        = 1'b0;
`ifdef AXI2APB_TIMEOUT_EN
      cnt_d           = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            // On a tie the write wins only if the last grant was a read.
            if (wr_req && !(rd_req && rr_last_write_q)) begin
               grant_wr = 1'b1;
            end else if (rd_req) begin
               grant_rd = 1'b1;
            end
            if (grant_wr || grant_rd) begin
               state_d         = SETUP;
               psel_d          = 1'b1;
               penable_d       = 1'b0;
               rr_last_write_d = grant_wr;
               pwrite_d        = grant_wr;
               paddr_d         = grant_wr ? axi_req_i.aw_addr : axi_req_i.ar_addr;
               pprot_d         = grant_wr ? axi_req_i.aw_prot : axi_req_i.ar_prot;
               pwdata_d        = grant_wr ? axi_req_i.w_data : '0;
               pstrb_d         = grant_wr ? axi_req_i.w_strb : '0;
               slverr_d        = 1'b0;
`ifdef AXI2APB_TIMEOUT_EN
               cnt_d           = '0;
`endif
            end
         end
         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
         end
         ACCESS: begin
            if (apb_resp_i.pready) begin
               state_d   = RESP;
               psel_d    = 1'b0;
               penable_d = 1'b0;
               slverr_d  = apb_resp_i.pslverr;
               b_valid_d = pwrite_q;
               r_valid_d = !pwrite_q;
               if (!pwrite_q) begin
                  rdata_d = apb_resp_i.prdata;
               end
            end
`ifdef AXI2APB_TIMEOUT_EN
            // This cycle is the TimeoutCycles-th without pready.
            else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
               state_d   = RESP;
               psel_d    = 1'b0;
               penable_d = 1'b0;
               slverr_d  = 1'b1;
               b_valid_d = pwrite_q;
               r_valid_d = !pwrite_q;
               rdata_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         RESP: begin
            if ((b_valid_q && axi_req_i.b_ready) || (r_valid_q && axi_req_i.r_ready)) begin
               state_d   = IDLE;
               b_valid_d = 1'b0;
               r_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q         <= IDLE;
         rr_last_write_q <= 1'b1;
         psel_q          <= 1'b0;
         penable_q       <= 1'b0;
         pwrite_q        <= 1'b0;
         paddr_q         <= '0;
         pprot_q         <= '0;
         pwdata_q        <= '0;
         pstrb_q         <= '0;
         b_valid_q       <= 1'b0;
         r_valid_q       <= 1'b0;
         slverr_q        <= 1'b0;
         rdata_q         <= '0;
`ifdef AXI2APB_TIMEOUT_EN
         cnt_q           <= '0;
`endif
      end else begin
         state_q         <= state_d;
         rr_last_write_q <= rr_last_write_d;
         psel_q          <= psel_d;
         penable_q       <= penable_d;
         pwrite_q        <= pwrite_d;
         paddr_q         <= paddr_d;
         pprot_q         <= pprot_d;
         pwdata_q        <= pwdata_d;
         pstrb_q         <= pstrb_d;
         b_valid_q       <= b_valid_d;
         r_valid_q       <= r_valid_d;
         slverr_q        <= slverr_d;
         rdata_q         <= rdata_d;
`ifdef AXI2APB_TIMEOUT_EN
         cnt_q           <= cnt_d;
`endif
      end
   end

   // AXI response; readies are the IDLE-state grant, everything else registered.
   always_comb begin
      axi_resp_o          = '0;
      axi_resp_o.aw_ready = grant_wr;
      axi_resp_o.w_ready  = grant_wr;
      axi_resp_o.ar_ready = grant_rd;
      axi_resp_o.b_valid  = b_valid_q;
      axi_resp_o.b_resp   = slverr_q ? RESP_SLVERR : RESP_OKAY;
      axi_resp_o.r_valid  = r_valid_q;
      axi_resp_o.r_resp   = slverr_q ? RESP_SLVERR : RESP_OKAY;
      axi_resp_o.r_data   = rdata_q;
   end

   // APB request fields straight from the payload registers.
   always_comb begin
      apb_req_o         = '0;
      apb_req_o.paddr   = paddr_q;
      apb_req_o.pprot   = pprot_q;
      apb_req_o.penable = penable_q;
      apb_req_o.pwrite  = pwrite_q;
      apb_req_o.pwdata  = pwdata_q;
      apb_req_o.pstrb   = pstrb_q;
   end

   assign apb_psel_o = psel_q;

endmodule
